cp0_exc_ctrl: RTL and testbench

//   Coprocessor-0 exception responder: consumes exception codes raised by pipeline stages (AdEL

---
 rtl/cp0_pkg.sv | 41 ++++
 rtl/cp0_exc_ctrl.sv | 121 ++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, exception codes, SR/Cause bit
// positions and the default handler/PRId values.
package cp0_pkg;

  // CP0 register numbers used by mfc0/mtc0
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // Exception codes; zero on the exception bus means "no exception"
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // SR field positions
  localparam int SR_IE_BIT  = 0;
  localparam int SR_EXL_BIT = 1;
  localparam int SR_IM_LSB  = 10;
  localparam int SR_IM_MSB  = 15;

  // Cause field positions
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_EXC_MSB = 6;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_IP_MSB  = 15;
  localparam int CAUSE_BD_BIT  = 31;

  localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_4180;
  localparam logic [31:0] PRID_DEFAULT         = 32'h0000_5A5A;

  // Exception-level state: NORMAL is SR.EXL=0, HANDLER is SR.EXL=1
  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_HANDLER = 1'b1
  } exc_state_e;

endpackage

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception responder. Arbitrates interrupts over synchronous
// exceptions, records EPC/Cause/BD, raises a same-cycle flush/redirect and
// serves mfc0/mtc0/eret. The SR.EXL bit is the NORMAL/HANDLER state flop.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT,
  parameter logic [31:0] PRID_VAL     = PRID_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code_m,
  input  logic [5:0]  hw_int,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic        eret,
  output logic [31:0] rdata,
  output logic        req,
  output logic [31:0] redirect
);

  exc_state_e  state_q, state_d;
  logic [5:0]  im_q, im_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // Arbitration: live hw_int gates interrupts; nothing is taken while in the handler
  always_comb begin
    int_req  = (|(hw_int & im_q)) & ie_q & (state_q == ST_NORMAL);
    exc_req  = (exc_code_m != EXC_NONE) & (state_q == ST_NORMAL);
    req      = int_req | exc_req;
    redirect = req ? HANDLER_ADDR : epc_q;
  end

  // Next-state: a taken exception overrides any mtc0/eret in the same cycle
  always_comb begin
    state_d = state_q;
    im_d    = im_q;
    ie_d    = ie_q;
    bd_d    = bd_q;
    ip_d    = hw_int;
    exc_d   = exc_q;
    epc_d   = epc_q;
    if (req) begin
      state_d = ST_HANDLER;
      bd_d    = bd_m;
      epc_d   = bd_m ? (pc_m - 32'd4) : pc_m;
      exc_d   = int_req ? EXC_INT : exc_code_m;
    end else begin
      if (we && (addr == CP0_SR)) begin
        im_d    = wdata[SR_IM_MSB:SR_IM_LSB];
        ie_d    = wdata[SR_IE_BIT];
        state_d = wdata[SR_EXL_BIT] ? ST_HANDLER : ST_NORMAL;
      end
      if (we && (addr == CP0_EPC)) begin
        epc_d = wdata;
      end
      // eret leaves the handler; harmless when already in NORMAL
      if (eret) begin
        state_d = ST_NORMAL;
      end
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_NORMAL;
      im_q    <= '0;
      ie_q    <= 1'b0;
      bd_q    <= 1'b0;
      ip_q    <= '0;
      exc_q   <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      im_q    <= im_d;
      ie_q    <= ie_d;
      bd_q    <= bd_d;
      ip_q    <= ip_d;
      exc_q   <= exc_d;
      epc_q   <= epc_d;
    end
  end

  // Assemble architectural SR/Cause views; unlisted bits read as zero
  always_comb begin
    sr_word                              = '0;
    sr_word[SR_IM_MSB:SR_IM_LSB]         = im_q;
    sr_word[SR_EXL_BIT]                  = (state_q == ST_HANDLER);
    sr_word[SR_IE_BIT]                   = ie_q;
    cause_word                           = '0;
    cause_word[CAUSE_BD_BIT]             = bd_q;
    cause_word[CAUSE_IP_MSB:CAUSE_IP_LSB] = ip_q;
    cause_word[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc_q;
  end

  // mfc0 read mux: current register contents, no bypass of a same-cycle write
  always_comb begin
    rdata = '0;
    case (addr)
      CP0_SR:    rdata = sr_word;
      CP0_CAUSE: rdata = cause_word;
      CP0_EPC:   rdata = epc_q;
      CP0_PRID:  rdata = PRID_VAL;
      default:   rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios plus a randomized
// run checked against a register-level behavioural model.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic [5:0]  hw_int;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        eret;
  logic [31:0] rdata;
  logic        req;
  logic [31:0] redirect;

  int checks   = 0;
  int failures = 0;

  // Model state: whole architectural registers as 32-bit words
  logic [31:0] m_sr, m_cause, m_epc;

  cp0_exc_ctrl dut (
    .clk(clk), .reset(reset), .pc_m(pc_m), .bd_m(bd_m), .exc_code_m(exc_code_m),
    .hw_int(hw_int), .we(we), .addr(addr), .wdata(wdata), .eret(eret),
    .rdata(rdata), .req(req), .redirect(redirect)
  );

  always #5 clk = ~clk;

  function automatic bit m_int();
    return ((hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic bit m_req();
    return m_int() || ((exc_code_m != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_redirect();
    return m_req() ? 32'h0000_4180 : m_epc;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_5A5A;
      default: return 32'h0;
    endcase
  endfunction

  task automatic idle();
    pc_m = 32'h0; bd_m = 1'b0; exc_code_m = 5'd0; hw_int = 6'd0;
    we = 1'b0; addr = 5'd0; wdata = 32'h0; eret = 1'b0;
  endtask

  // Advance one clock; model computes its next state from the pre-edge inputs
  task automatic tick();
    logic [31:0] n_sr, n_cause, n_epc;
    bit r, i;
    r = m_req();
    i = m_int();
    n_sr    = m_sr;
    n_epc   = m_epc;
    n_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, hw_int} << 10);
    if (r) begin
      n_sr    = m_sr | 32'h2;
      n_epc   = bd_m ? pc_m - 32'd4 : pc_m;
      n_cause = {bd_m, 15'd0, hw_int, 3'd0, (i ? 5'd0 : exc_code_m), 2'd0};
    end else begin
      if (we && addr == 5'd12) n_sr = wdata & 32'h0000_FC03;
      if (we && addr == 5'd14) n_epc = wdata;
      if (eret) n_sr = n_sr & ~32'h2;
    end
    @(posedge clk);
    if (reset) begin
      m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
    end else begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end
    @(negedge clk);
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    idle();
    reset = 1'b0;
    m_sr = 0; m_cause = 0; m_epc = 0;
    @(negedge clk);
    for (int a = 12; a <= 15; a++) begin
      read_reg(a[4:0], v);
      checks++;
      if (v !== m_rdata(a[4:0])) begin
        failures++;
        $display("FAIL reset_rdata addr=%0d got=%h exp=%h", a, v, m_rdata(a[4:0]));
      end
    end
    checks++;
    if (req !== 1'b0 || redirect !== 32'h0) begin
      failures++;
      $display("FAIL reset_req req=%b redirect=%h exp req=0 redirect=0", req, redirect);
    end
    reset = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_fetch_fault();
    logic [31:0] v;
    idle();
    exc_code_m = 5'd4; pc_m = 32'h3001; bd_m = 1'b0;
    #1;
    checks++;
    if (req !== 1'b1 || redirect !== 32'h4180) begin
      failures++;
      $display("FAIL fetch_req req=%b redirect=%h exp 1/00004180", req, redirect);
    end
    tick();
    idle();
    read_reg(5'd14, v);
    checks++;
    if (v !== 32'h3001) begin failures++; $display("FAIL fetch_epc got=%h exp=00003001", v); end
    read_reg(5'd13, v);
    checks++;
    if (v[6:2] !== 5'd4 || v[31] !== 1'b0) begin failures++; $display("FAIL fetch_cause got=%h exp exc=4 bd=0", v); end
    read_reg(5'd12, v);
    checks++;
    if (v[1] !== 1'b1 || req !== 1'b0) begin failures++; $display("FAIL fetch_exl sr=%h req=%b exp exl=1 req=0", v, req); end
    eret = 1'b1; tick(); idle();
    $display("test_fetch_fault done");
  endtask

  task automatic test_delay_slot();
    logic [31:0] v;
    idle();
    exc_code_m = 5'd12; pc_m = 32'h3010; bd_m = 1'b1;
    tick();
    idle();
    read_reg(5'd14, v);
    checks++;
    if (v !== 32'h300C) begin failures++; $display("FAIL ds_epc got=%h exp=0000300c", v); end
    read_reg(5'd13, v);
    checks++;
    if (v !== 32'h8000_0030) begin failures++; $display("FAIL ds_cause got=%h exp=80000030", v); end
    eret = 1'b1; tick(); idle();
    $display("test_delay_slot done");
  endtask

  task automatic test_interrupt();
    logic [31:0] v;
    idle();
    we = 1'b1; addr = 5'd12; wdata = 32'h0000_0401;
    tick();
    idle();
    hw_int = 6'b000001;
    #1;
    checks++;
    if (req !== 1'b1 || redirect !== 32'h4180) begin failures++; $display("FAIL int_req req=%b redirect=%h exp 1/00004180", req, redirect); end
    tick();
    read_reg(5'd13, v);
    checks++;
    if (v !== 32'h0000_0400) begin failures++; $display("FAIL int_cause got=%h exp=00000400", v); end
    hw_int = 6'd0;
    eret = 1'b1; tick(); idle();
    we = 1'b1; addr = 5'd12; wdata = 32'h0000_0400;
    tick();
    idle();
    hw_int = 6'b000001;
    #1;
    checks++;
    if (req !== 1'b0) begin failures++; $display("FAIL int_ie0 req=%b exp=0", req); end
    idle();
    $display("test_interrupt done");
  endtask

  task automatic test_priority_nesting();
    logic [31:0] v;
    idle();
    we = 1'b1; addr = 5'd12; wdata = 32'h0000_0401;
    tick();
    idle();
    hw_int = 6'b000001; exc_code_m = 5'd10; pc_m = 32'h3040;
    tick();
    hw_int = 6'd0; exc_code_m = 5'd0;
    read_reg(5'd13, v);
    checks++;
    if (v[6:2] !== 5'd0) begin failures++; $display("FAIL prio_exccode got=%0d exp=0", v[6:2]); end
    read_reg(5'd14, v);
    checks++;
    if (v !== 32'h3040) begin failures++; $display("FAIL prio_epc got=%h exp=00003040", v); end
    exc_code_m = 5'd5; hw_int = 6'b111111;
    #1;
    checks++;
    if (req !== 1'b0 || redirect !== 32'h3040) begin failures++; $display("FAIL nest_req req=%b redirect=%h exp 0/00003040", req, redirect); end
    idle();
    eret = 1'b1; tick(); idle();
    we = 1'b1; addr = 5'd12; wdata = 32'h0; tick(); idle();
    $display("test_priority_nesting done");
  endtask

  task automatic test_eret();
    logic [31:0] v;
    idle();
    exc_code_m = 5'd5; pc_m = 32'h3050;
    tick();
    idle();
    we = 1'b1; addr = 5'd14; wdata = 32'h3020;
    tick();
    idle();
    eret = 1'b1;
    #1;
    checks++;
    if (req !== 1'b0 || redirect !== 32'h3020) begin failures++; $display("FAIL eret_redirect req=%b redirect=%h exp 0/00003020", req, redirect); end
    tick();
    idle();
    read_reg(5'd12, v);
    checks++;
    if (v[1] !== 1'b0) begin failures++; $display("FAIL eret_exl got=%b exp=0", v[1]); end
    we = 1'b1; addr = 5'd13; wdata = 32'hFFFF_FFFF;
    tick();
    idle();
    read_reg(5'd13, v);
    checks++;
    if (v !== 32'h0000_0014) begin failures++; $display("FAIL mtc0_cause got=%h exp=00000014", v); end
    $display("test_eret done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    idle();
    exc_code_m = 5'd10; pc_m = 32'h3060;
    tick();
    idle();
    eret = 1'b1; we = 1'b1; addr = 5'd14; wdata = 32'h3070;
    #1;
    checks++;
    if (redirect !== 32'h3060) begin failures++; $display("FAIL eret_we_redirect got=%h exp=00003060", redirect); end
    tick();
    idle();
    read_reg(5'd14, v);
    checks++;
    if (v !== 32'h3070) begin failures++; $display("FAIL eret_we_epc got=%h exp=00003070", v); end
    exc_code_m = 5'd12; pc_m = 32'h3080; we = 1'b1; addr = 5'd14; wdata = 32'hDEAD_BEEF;
    tick();
    idle();
    read_reg(5'd14, v);
    checks++;
    if (v !== 32'h3080) begin failures++; $display("FAIL req_we_epc got=%h exp=00003080", v); end
    eret = 1'b1; tick(); idle();
    eret = 1'b1; exc_code_m = 5'd4; pc_m = 32'h3090;
    #1;
    checks++;
    if (req !== 1'b1) begin failures++; $display("FAIL forced_req got=%b exp=1", req); end
    tick();
    idle();
    read_reg(5'd12, v);
    checks++;
    if (v[1] !== 1'b1) begin failures++; $display("FAIL forced_exl got=%b exp=1", v[1]); end
    eret = 1'b1; tick(); idle();
    $display("test_back_to_back done");
  endtask

  task automatic test_random();
    logic [4:0] codes [7];
    int errs = 0;
    codes = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd10, 5'd12};
    for (int n = 0; n < 400; n++) begin
      exc_code_m = ($urandom_range(0, 3) == 0) ? codes[$urandom_range(0, 6)] : 5'd0;
      pc_m       = $urandom;
      bd_m       = $urandom_range(0, 1) == 1;
      hw_int     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      eret       = $urandom_range(0, 3) == 0;
      we         = $urandom_range(0, 2) == 0;
      addr       = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
      wdata      = $urandom;
      if (eret && we && addr == 5'd12) we = 1'b0;
      #1;
      checks++;
      if (req !== m_req() || redirect !== m_redirect() || rdata !== m_rdata(addr)) begin
        failures++;
        errs++;
        if (errs <= 10)
          $display("FAIL random n=%0d req=%b/%b redirect=%h/%h rdata[%0d]=%h/%h (got/exp)",
                   n, req, m_req(), redirect, m_redirect(), addr, rdata, m_rdata(addr));
      end
      tick();
    end
    idle();
    $display("test_random done");
  endtask

  task automatic test_reset_mid_handler();
    logic [31:0] v;
    idle();
    if (m_sr[1]) begin eret = 1'b1; tick(); idle(); end
    exc_code_m = 5'd4; pc_m = 32'h30A0;
    tick();
    idle();
    #2;
    reset = 1'b0;
    m_sr = 0; m_cause = 0; m_epc = 0;
    for (int a = 12; a <= 14; a++) begin
      read_reg(a[4:0], v);
      checks++;
      if (v !== 32'h0) begin failures++; $display("FAIL midreset_rdata addr=%0d got=%h exp=0", a, v); end
    end
    exc_code_m = 5'd4;
    #1;
    checks++;
    if (req !== 1'b1 || redirect !== 32'h4180) begin failures++; $display("FAIL midreset_req req=%b redirect=%h exp 1/00004180", req, redirect); end
    exc_code_m = 5'd0;
    #1;
    checks++;
    if (req !== 1'b0 || redirect !== 32'h0) begin failures++; $display("FAIL midreset_idle req=%b redirect=%h exp 0/0", req, redirect); end
    reset = 1'b1;
    tick();
    $display("test_reset_mid_handler done");
  endtask

  initial begin
    test_reset();
    test_fetch_fault();
    test_delay_slot();
    test_interrupt();
    test_priority_nesting();
    test_eret();
    test_back_to_back();
    test_random();
    test_reset_mid_handler();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
